// File: rtl/perf_counter_mmio.sv
// perf_counter_mmio: seven free-running performance counters (I-cache, D-cache,
// L2 done/stall plus total cycles) exposed through a small MMIO window with a
// control register for clear and freeze.
// Optional build macro: PERF_L2_EN builds the l2_done / l2_stall counters;
// without it those offsets read 0 and the l2_* strobes are ignored.
module perf_counter_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_access,
    input  logic        instr_resp,
    input  logic        data_access,
    input  logic        data_resp,
    input  logic        l2_access,
    input  logic        l2_resp,
    input  logic        mmio_read,
    input  logic        mmio_write,
    input  logic [31:0] mmio_address,
    input  logic [31:0] mmio_wdata,
    output logic        mmio_sel,
    output logic [31:0] mmio_rdata,
    output logic        mmio_resp
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_WAIT
    } state_t;

    localparam logic [5:0] OFS_INSTR_DONE = 6'h00;
    localparam logic [5:0] OFS_INSTR_STALL = 6'h01;
    localparam logic [5:0] OFS_DATA_DONE  = 6'h02;
    localparam logic [5:0] OFS_DATA_STALL = 6'h03;
    localparam logic [5:0] OFS_L2_DONE    = 6'h04;
    localparam logic [5:0] OFS_L2_STALL   = 6'h05;
    localparam logic [5:0] OFS_CYCLES     = 6'h06;
    localparam logic [5:0] OFS_CTRL       = 6'h07;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic                 freeze;
    logic                 req_ctrl_write;
    logic [1:0]           req_wdata;
    logic                 clear_now;
    logic [31:0]          rd_val;
    logic [5:0]           offset;

    logic [CNT_WIDTH-1:0] instr_done;
    logic [CNT_WIDTH-1:0] instr_stall;
    logic [CNT_WIDTH-1:0] data_done;
    logic [CNT_WIDTH-1:0] data_stall;
    logic [CNT_WIDTH-1:0] cycles;
`ifdef PERF_L2_EN
    logic [CNT_WIDTH-1:0] l2_done;
    logic [CNT_WIDTH-1:0] l2_stall;
`endif

    // Byte-lane bits and upper write-data bits carry no meaning for this block.
    logic unused_bits;
`ifdef PERF_L2_EN
    assign unused_bits = ^{mmio_wdata[31:2], mmio_address[1:0]};
`else
    assign unused_bits = ^{mmio_wdata[31:2], mmio_address[1:0], l2_access, l2_resp};
`endif

    assign mmio_sel  = (mmio_address[31:8] == BASE_ADDR[31:8]);
    assign offset    = mmio_address[7:2];
    assign clear_now = (state == ST_RESP) && req_ctrl_write && req_wdata[0];

    // Read mux over the current (pre-increment) counter values, zero-extended.
    always_comb begin
        rd_val = '0;
        case (offset)
            OFS_INSTR_DONE:  rd_val[CNT_WIDTH-1:0] = instr_done;
            OFS_INSTR_STALL: rd_val[CNT_WIDTH-1:0] = instr_stall;
            OFS_DATA_DONE:   rd_val[CNT_WIDTH-1:0] = data_done;
            OFS_DATA_STALL:  rd_val[CNT_WIDTH-1:0] = data_stall;
`ifdef PERF_L2_EN
            OFS_L2_DONE:     rd_val[CNT_WIDTH-1:0] = l2_done;
            OFS_L2_STALL:    rd_val[CNT_WIDTH-1:0] = l2_stall;
`else
            OFS_L2_DONE:     rd_val = '0;
            OFS_L2_STALL:    rd_val = '0;
`endif
            OFS_CYCLES:      rd_val[CNT_WIDTH-1:0] = cycles;
            OFS_CTRL:        rd_val = {31'b0, freeze};
            default:         rd_val = '0;
        endcase
    end

    // Event counters: clear from the control register beats freeze and counting.
    always_ff @(posedge clk) begin
        if (rst || clear_now) begin
            instr_done  <= '0;
            instr_stall <= '0;
            data_done   <= '0;
            data_stall  <= '0;
            cycles      <= '0;
`ifdef PERF_L2_EN
            l2_done     <= '0;
            l2_stall    <= '0;
`endif
        end else if (!freeze) begin
            cycles <= cycles + CNT_ONE;
            if (instr_access && instr_resp)
                instr_done <= instr_done + CNT_ONE;
            if (instr_access && !instr_resp)
                instr_stall <= instr_stall + CNT_ONE;
            if (data_access && data_resp)
                data_done <= data_done + CNT_ONE;
            if (data_access && !data_resp)
                data_stall <= data_stall + CNT_ONE;
`ifdef PERF_L2_EN
            if (l2_access && l2_resp)
                l2_done <= l2_done + CNT_ONE;
            if (l2_access && !l2_resp)
                l2_stall <= l2_stall + CNT_ONE;
`endif
        end
    end

    // MMIO transaction FSM: accept, respond one cycle later, then one dead cycle
    // so a requester still holding its strobe is not accepted twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            mmio_resp      <= 1'b0;
            mmio_rdata     <= '0;
            freeze         <= 1'b0;
            req_ctrl_write <= 1'b0;
            req_wdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mmio_resp <= 1'b0;
                    if (mmio_sel && (mmio_read || mmio_write)) begin
                        state          <= ST_RESP;
                        mmio_resp      <= 1'b1;
                        mmio_rdata     <= mmio_write ? 32'b0 : rd_val;
                        req_ctrl_write <= mmio_write && (offset == OFS_CTRL);
                        req_wdata      <= mmio_wdata[1:0];
                    end
                end
                ST_RESP: begin
                    state      <= ST_WAIT;
                    mmio_resp  <= 1'b0;
                    mmio_rdata <= '0;
                    if (req_ctrl_write)
                        freeze <= req_wdata[1];
                end
                ST_WAIT: begin
                    state     <= ST_IDLE;
                    mmio_resp <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mmio_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_mmio.sv
// Testbench for perf_counter_mmio: two instances (32-bit and 4-bit counters)
// share all stimulus; a scoreboard queue holds expected read data and a
// negedge monitor pops one entry per response pulse.
module tb_perf_counter_mmio;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

`ifdef PERF_L2_EN
    localparam logic [31:0] L2_DONE_EXP  = 32'd10;
    localparam logic [31:0] L2_STALL_EXP = 32'd7;
`else
    localparam logic [31:0] L2_DONE_EXP  = 32'd0;
    localparam logic [31:0] L2_STALL_EXP = 32'd0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp32;
        logic [31:0] exp4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_access, instr_resp;
    logic        data_access, data_resp;
    logic        l2_access, l2_resp;
    logic        mmio_read, mmio_write;
    logic [31:0] mmio_address, mmio_wdata;
    logic        sel32, resp32, sel4, resp4;
    logic [31:0] rdata32, rdata4;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    perf_counter_mmio #(.BASE_ADDR(BASE), .CNT_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .instr_access(instr_access), .instr_resp(instr_resp),
        .data_access(data_access), .data_resp(data_resp),
        .l2_access(l2_access), .l2_resp(l2_resp),
        .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_address(mmio_address), .mmio_wdata(mmio_wdata),
        .mmio_sel(sel32), .mmio_rdata(rdata32), .mmio_resp(resp32)
    );

    perf_counter_mmio #(.BASE_ADDR(BASE), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .instr_access(instr_access), .instr_resp(instr_resp),
        .data_access(data_access), .data_resp(data_resp),
        .l2_access(l2_access), .l2_resp(l2_resp),
        .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_address(mmio_address), .mmio_wdata(mmio_wdata),
        .mmio_sel(sel4), .mmio_rdata(rdata4), .mmio_resp(resp4)
    );

    always #5 clk = ~clk;

    // Shared comparison: one vector counted, one FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both instances and confirm the reset-state outputs.
    task automatic doReset();
        rst = 1'b1;
        instr_access = 0; instr_resp = 0;
        data_access = 0;  data_resp = 0;
        l2_access = 0;    l2_resp = 0;
        mmio_read = 0;    mmio_write = 0;
        mmio_address = '0; mmio_wdata = '0;
        tick();
        tick();
        checkOutput("rst_resp32", {31'b0, resp32}, 32'd0);
        checkOutput("rst_rdata32", rdata32, 32'd0);
        checkOutput("rst_rdata4", rdata4, 32'd0);
        rst = 1'b0;
    endtask

    // One full transaction: accept, response, dead cycle; expectation queued first.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string name,
                                 input logic [31:0] exp32, input logic [31:0] exp4);
        exp_t e;
        e.name = name; e.exp32 = exp32; e.exp4 = exp4;
        sb.push_back(e);
        mmio_read = rd; mmio_write = wr;
        mmio_address = addr; mmio_wdata = wdata;
        tick();
        mmio_read = 0; mmio_write = 0;
        tick();
        tick();
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (resp32 || resp4) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_resp", {31'b0, resp32}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput({e.name, "_resp4"}, {31'b0, resp4}, 32'd1);
                    checkOutput({e.name, "_w32"}, rdata32, e.exp32);
                    checkOutput({e.name, "_w4"}, rdata4, e.exp4);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state and cycle counter snapshot timing
        doReset();
        repeat (5) tick();
        applyStimulus(1, 0, BASE + 32'h18, 0, "cyc_at5", 32'd5, 32'd5);
        applyStimulus(1, 0, BASE + 32'h00, 0, "instr_done0", 0, 0);
        applyStimulus(1, 0, BASE + 32'h04, 0, "instr_stall0", 0, 0);
        applyStimulus(1, 0, BASE + 32'h08, 0, "data_done0", 0, 0);
        applyStimulus(1, 0, BASE + 32'h0C, 0, "data_stall0", 0, 0);
        applyStimulus(1, 0, BASE + 32'h10, 0, "l2_done0", 0, 0);
        applyStimulus(1, 0, BASE + 32'h14, 0, "l2_stall0", 0, 0);

        // D-cache: 3 stalled cycles then one completion
        doReset();
        data_access = 1;
        repeat (3) tick();
        data_resp = 1;
        tick();
        data_access = 0; data_resp = 0;
        applyStimulus(1, 0, BASE + 32'h0C, 0, "data_stall", 32'd3, 32'd3);
        applyStimulus(1, 0, BASE + 32'h08, 0, "data_done", 32'd1, 32'd1);
        applyStimulus(1, 0, BASE + 32'h00, 0, "instr_done_d", 0, 0);
        applyStimulus(1, 0, BASE + 32'h04, 0, "instr_stall_d", 0, 0);
        applyStimulus(1, 0, BASE + 32'h10, 0, "l2_done_d", 0, 0);

        // Freeze holds counters; unfreeze resumes two cycles after accept
        doReset();
        applyStimulus(0, 1, BASE + 32'h1C, 32'h2, "freeze_wr", 0, 0);
        repeat (10) tick();
        applyStimulus(1, 0, BASE + 32'h18, 0, "frozen_a", 32'd2, 32'd2);
        applyStimulus(1, 0, BASE + 32'h18, 0, "frozen_b", 32'd2, 32'd2);
        applyStimulus(1, 0, BASE + 32'h1C, 0, "ctrl_frozen", 32'd1, 32'd1);
        applyStimulus(0, 1, BASE + 32'h1C, 32'h0, "unfreeze_wr", 0, 0);
        applyStimulus(1, 0, BASE + 32'h18, 0, "resume_a", 32'd3, 32'd3);
        applyStimulus(1, 0, BASE + 32'h18, 0, "resume_b", 32'd6, 32'd6);

        // Clear under continuous I-cache hits, then clear+freeze together
        doReset();
        instr_access = 1; instr_resp = 1;
        repeat (3) tick();
        applyStimulus(0, 1, BASE + 32'h1C, 32'h1, "clear_wr", 0, 0);
        applyStimulus(1, 0, BASE + 32'h00, 0, "post_clear_a", 32'd1, 32'd1);
        applyStimulus(1, 0, BASE + 32'h00, 0, "post_clear_b", 32'd4, 32'd4);
        applyStimulus(1, 0, BASE + 32'h18, 0, "post_clear_cyc", 32'd7, 32'd7);
        applyStimulus(1, 0, BASE + 32'h1C, 0, "ctrl_selfclr", 0, 0);
        applyStimulus(0, 1, BASE + 32'h1C, 32'h3, "clr_frz_wr", 0, 0);
        applyStimulus(1, 0, BASE + 32'h00, 0, "clr_frz_instr", 0, 0);
        applyStimulus(1, 0, BASE + 32'h18, 0, "clr_frz_cyc", 0, 0);
        applyStimulus(1, 0, BASE + 32'h1C, 0, "clr_frz_ctrl", 32'd1, 32'd1);
        instr_access = 0; instr_resp = 0;

        // Held request, out-of-window request, decode corner cases
        doReset();
        begin
            exp_t e;
            e.name = "held_a"; e.exp32 = 32'd0; e.exp4 = 32'd0; sb.push_back(e);
            e.name = "held_b"; e.exp32 = 32'd3; e.exp4 = 32'd3; sb.push_back(e);
        end
        mmio_read = 1; mmio_address = BASE + 32'h18;
        #1;
        checkOutput("sel_inside", {31'b0, sel32}, 32'd1);
        repeat (6) tick();
        mmio_read = 1; mmio_address = 32'h0000_1018;
        #1;
        checkOutput("sel_outside32", {31'b0, sel32}, 32'd0);
        checkOutput("sel_outside4", {31'b0, sel4}, 32'd0);
        repeat (3) tick();
        mmio_read = 0;
        applyStimulus(1, 0, BASE + 32'h40, 0, "rd_0x40", 0, 0);
        applyStimulus(1, 0, BASE + 32'h1B, 0, "rd_lowbits", 32'd12, 32'd12);
        applyStimulus(1, 1, BASE + 32'h18, 32'h1, "rd_wr_both", 0, 0);
        applyStimulus(1, 0, BASE + 32'h18, 0, "cyc_not_cleared", 32'd18, 32'd2);
        applyStimulus(0, 1, BASE + 32'h40, 32'h3, "wr_0x40", 0, 0);
        applyStimulus(1, 0, BASE + 32'h1C, 0, "ctrl_after_0x40", 0, 0);

        // Reset alongside a request: no response may appear
        mmio_read = 1; mmio_address = BASE + 32'h18; rst = 1;
        tick();
        tick();
        mmio_read = 0;

        // 17 I-cache hits wrap the 4-bit instance; L2 counters per build
        doReset();
        instr_access = 1; instr_resp = 1;
        l2_access = 1; l2_resp = 1;
        repeat (10) tick();
        l2_resp = 0;
        repeat (7) tick();
        instr_access = 0; instr_resp = 0; l2_access = 0;
        applyStimulus(1, 0, BASE + 32'h00, 0, "wrap_instr", 32'd17, 32'd1);
        applyStimulus(1, 0, BASE + 32'h18, 0, "wrap_cyc", 32'd20, 32'd4);
        applyStimulus(1, 0, BASE + 32'h10, 0, "l2_done", L2_DONE_EXP, L2_DONE_EXP);
        applyStimulus(1, 0, BASE + 32'h14, 0, "l2_stall", L2_STALL_EXP, L2_STALL_EXP);
        applyStimulus(1, 0, BASE + 32'h08, 0, "data_done_wrap", 0, 0);

        repeat (4) tick();
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
